hazard_stall_unit: RTL and testbench

- Sequential hazard, stall and halt controller for the 5-stage pipelined RV32I core.
- Sits beside the ID stage and keeps a scoreboard of in-flight register writers in the EX, MEM and WB stages.
- Drives pc_write and if_id_write, and drives is_nop, the bubble-insert input of the ID control decoder.
- Runs the ecall halt sequence: drains the pipeline, then raises is_halted.

---
 rtl/hazard_stall_unit_pkg.sv | 31 +++
 rtl/hazard_stall_unit_scoreboard.sv | 65 ++++++
 rtl/hazard_stall_unit.sv | 121 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the ID-stage hazard/stall/halt controller:
// FSM encodings, register constants and the scoreboard entry layout.
package hazard_stall_unit_pkg;

  localparam int REG_W = 5;

  localparam logic [REG_W-1:0] REG_X0  = 5'd0;
  localparam logic [REG_W-1:0] REG_X17 = 5'd17;
  localparam int               ECALL_HALT_VAL = 10;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_RUN    = 2'd0;
  localparam logic [ST_W-1:0] ST_DRAIN  = 2'd1;
  localparam logic [ST_W-1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // True when an in-flight writer produces a register the ID instruction reads.
  function automatic logic src_match(input sb_entry_t e,
                                     input logic use_rs1, input logic [REG_W-1:0] rs1,
                                     input logic use_rs2, input logic [REG_W-1:0] rs2);
    return e.valid && ((use_rs1 && (rs1 == e.rd)) || (use_rs2 && (rs2 == e.rd)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_scoreboard.sv
// Three-stage (EX/MEM/WB) writer scoreboard plus the RAW and ecall
// stall decision against the instruction currently in ID.
module hazard_scoreboard
  import hazard_stall_unit_pkg::*;
#(
  parameter bit FORWARDING = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid_i,
  input  logic             id_flush_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             id_is_ecall_i,
  input  logic             is_nop_i,
  output logic             stall_o
);

  sb_entry_t ex_q, mem_q, wb_q, ex_d;
  logic      ex_match, mem_match, raw_stall, ecall_stall;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    ex_d = SB_EMPTY;
    if (id_valid_i && id_reg_write_i && !is_nop_i && !id_flush_i && (id_rd_i != REG_X0)) begin
      ex_d = '{valid: 1'b1, rd: id_rd_i, is_load: id_mem_read_i};
    end
  end

  // NOTE: the entries are control state, not storage; a stale valid bit after reset would raise a false stall, so all three are reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= SB_EMPTY;
      mem_q <= SB_EMPTY;
      wb_q  <= SB_EMPTY;
    end else begin
      // NOTE: non-blocking assignments make this a true shift; blocking would copy EX straight through to WB.
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // WB is tracked but never matched: the register file writes before it reads.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  assign ex_match  = src_match(ex_q,  id_use_rs1_i, id_rs1_i, id_use_rs2_i, id_rs2_i);
  assign mem_match = src_match(mem_q, id_use_rs1_i, id_rs1_i, id_use_rs2_i, id_rs2_i);

  assign raw_stall = FORWARDING ? (ex_match && ex_q.is_load) : (ex_match || mem_match);

  // ecall reads x17 in ID where no forwarding path exists, so it waits for EX and MEM.
  assign ecall_stall = id_is_ecall_i &&
                       ((ex_q.valid  && (ex_q.rd  == REG_X17)) ||
                        (mem_q.valid && (mem_q.rd == REG_X17)));

  assign stall_o = id_valid_i && !id_flush_i && (raw_stall || ecall_stall);

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard, stall and ecall-halt controller beside the ID stage of the
// 5-stage RV32I pipeline; owns the RUN/DRAIN/HALTED FSM and stall counter.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int FORWARDING   = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_flush,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_is_ecall,
  input  logic             id_x17_is_10,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             is_nop,
  output logic             is_halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  logic [ST_W-1:0]    state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               stall, halt_ecall;

  hazard_scoreboard #(
    .FORWARDING (FORWARDING != 0)
  ) u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .id_valid_i     (id_valid),
    .id_flush_i     (id_flush),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_use_rs1_i   (id_use_rs1),
    .id_use_rs2_i   (id_use_rs2),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .id_mem_read_i  (id_mem_read),
    .id_is_ecall_i  (id_is_ecall),
    .is_nop_i       (is_nop),
    .stall_o        (stall)
  );

  // x17 is sampled only once the ecall is no longer stalled, so a stale read never halts.
  assign halt_ecall = id_valid && id_is_ecall && !stall && !id_flush && id_x17_is_10;

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    stall_count_d = stall_count_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    is_nop        = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (stall) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          is_nop      = 1'b1;
          if (stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
        end else begin
          is_nop = id_flush || !id_valid;
          if (halt_ecall) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        is_nop      = 1'b1;
        if (drain_cnt_q == '0) state_d = ST_HALTED;
        else                   drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
      end
      ST_HALTED: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        is_nop      = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    // While reset is held the front end runs freely with no bubble.
    if (reset) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      is_nop      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      drain_cnt_q   <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign is_halted   = (state_q == ST_HALTED);
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: directed instruction sequences push hand-computed
// per-cycle expectations; a negedge monitor pops and compares them.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid, id_flush, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, id_is_ecall, id_x17_is_10;

  logic        f_pw, f_ifw, f_nop, f_halt;
  logic [31:0] f_cnt;
  logic        n_pw, n_ifw, n_nop, n_halt;
  logic [1:0]  n_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.FORWARDING(1), .DRAIN_CYCLES(3), .CNT_W(32)) u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_is_ecall(id_is_ecall), .id_x17_is_10(id_x17_is_10),
    .pc_write(f_pw), .if_id_write(f_ifw), .is_nop(f_nop), .is_halted(f_halt),
    .stall_count(f_cnt)
  );

  hazard_stall_unit #(.FORWARDING(0), .DRAIN_CYCLES(3), .CNT_W(2)) u_nofwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_is_ecall(id_is_ecall), .id_x17_is_10(id_x17_is_10),
    .pc_write(n_pw), .if_id_write(n_ifw), .is_nop(n_nop), .is_halted(n_halt),
    .stall_count(n_cnt)
  );

  typedef struct packed {
    logic       valid, flush;
    logic [4:0] rs1, rs2;
    logic       use1, use2;
    logic [4:0] rd;
    logic       regw, mrd, ecall, x10;
  } id_t;

  typedef struct {
    bit          sel;   // 1 = u_fwd, 0 = u_nofwd
    logic        pw, nop, halt;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  localparam bit FWD = 1'b1;
  localparam bit NOF = 1'b0;

  function automatic id_t bub();
    return '0;
  endfunction

  function automatic id_t alu(input logic [4:0] rd, rs1, rs2, input logic use2);
    id_t i = '0;
    i.valid = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.use1 = 1'b1; i.use2 = use2; i.regw = 1'b1;
    return i;
  endfunction

  function automatic id_t ld(input logic [4:0] rd, rs1);
    id_t i = alu(rd, rs1, 5'd0, 1'b0);
    i.mrd = 1'b1;
    return i;
  endfunction

  function automatic id_t ecall(input logic x10);
    id_t i = '0;
    i.valid = 1'b1; i.ecall = 1'b1; i.x10 = x10;
    return i;
  endfunction

  function automatic id_t flushed(input id_t i);
    id_t o = i;
    o.flush = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive ID after the edge, optionally pulse reset, queue expectation.
  task automatic step(input bit sel, input id_t i, input bit rst_lvl, input bit rst_pulse,
                      input logic pw, input logic nop, input logic halt,
                      input int cnt, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst_lvl;
    id_valid     = i.valid;     id_flush     = i.flush;
    id_rs1       = i.rs1;       id_rs2       = i.rs2;
    id_use_rs1   = i.use1;      id_use_rs2   = i.use2;
    id_rd        = i.rd;        id_reg_write = i.regw;
    id_mem_read  = i.mrd;       id_is_ecall  = i.ecall;
    id_x17_is_10 = i.x10;
    if (rst_pulse) begin
      reset = 1'b1;
      #2;
      reset = 1'b0;
    end
    e.sel = sel; e.pw = pw; e.nop = nop; e.halt = halt; e.cnt = cnt; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic run(input bit sel, input id_t i, input logic nop, input int cnt, input string tag);
    step(sel, i, 1'b0, 1'b0, 1'b1, nop, 1'b0, cnt, tag);
  endtask

  task automatic stl(input bit sel, input id_t i, input int cnt, input string tag);
    step(sel, i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cnt, tag);
  endtask

  task automatic drn(input bit sel, input id_t i, input logic halt, input int cnt, input string tag);
    step(sel, i, 1'b0, 1'b0, 1'b0, 1'b1, halt, cnt, tag);
  endtask

  task automatic do_reset(input bit sel, input string tag);
    step(sel, bub(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, {tag, ".rst0"});
    step(sel, bub(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, {tag, ".rst1"});
  endtask

  // Monitor: compares the selected DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel) begin
          check({e.tag, ".pc_write"},    32'(f_pw),   32'(e.pw));
          check({e.tag, ".if_id_write"}, 32'(f_ifw),  32'(e.pw));
          check({e.tag, ".is_nop"},      32'(f_nop),  32'(e.nop));
          check({e.tag, ".is_halted"},   32'(f_halt), 32'(e.halt));
          check({e.tag, ".stall_count"}, f_cnt,       e.cnt);
        end else begin
          check({e.tag, ".pc_write"},    32'(n_pw),   32'(e.pw));
          check({e.tag, ".if_id_write"}, 32'(n_ifw),  32'(e.pw));
          check({e.tag, ".is_nop"},      32'(n_nop),  32'(e.nop));
          check({e.tag, ".is_halted"},   32'(n_halt), 32'(e.halt));
          check({e.tag, ".stall_count"}, 32'(n_cnt),  e.cnt);
        end
      end
    end
  end

  initial begin
    {id_valid, id_flush, id_use_rs1, id_use_rs2, id_reg_write,
     id_mem_read, id_is_ecall, id_x17_is_10} = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;

    // Load-use with forwarding: exactly one bubble.
    do_reset(FWD, "s1");
    run(FWD, ld(5'd5, 5'd1),               1'b0, 0, "s1.lw");
    stl(FWD, alu(5'd6, 5'd5, 5'd1, 1'b1),        0, "s1.add_stall");
    run(FWD, alu(5'd6, 5'd5, 5'd1, 1'b1),  1'b0, 1, "s1.add_go");
    run(FWD, bub(),                        1'b1, 1, "s1.bubble");

    // No forwarding: EX dep 2 stalls, MEM dep 1, x0 none, 2-bit counter saturates.
    do_reset(NOF, "s2");
    run(NOF, alu(5'd5,  5'd0, 5'd0, 1'b0), 1'b0, 0, "s2.addi5");
    stl(NOF, alu(5'd6,  5'd5, 5'd5, 1'b1),       0, "s2.ex_stall0");
    stl(NOF, alu(5'd6,  5'd5, 5'd5, 1'b1),       1, "s2.ex_stall1");
    run(NOF, alu(5'd6,  5'd5, 5'd5, 1'b1), 1'b0, 2, "s2.ex_go");
    run(NOF, alu(5'd7,  5'd0, 5'd0, 1'b0), 1'b0, 2, "s2.addi7");
    run(NOF, alu(5'd11, 5'd0, 5'd0, 1'b0), 1'b0, 2, "s2.indep");
    stl(NOF, alu(5'd12, 5'd7, 5'd7, 1'b1),       2, "s2.mem_stall");
    run(NOF, alu(5'd12, 5'd7, 5'd7, 1'b1), 1'b0, 3, "s2.mem_go");
    run(NOF, alu(5'd0,  5'd0, 5'd0, 1'b0), 1'b0, 3, "s2.addi_x0");
    run(NOF, alu(5'd13, 5'd0, 5'd0, 1'b1), 1'b0, 3, "s2.read_x0");
    run(NOF, alu(5'd14, 5'd0, 5'd0, 1'b0), 1'b0, 3, "s2.addi14");
    stl(NOF, alu(5'd15, 5'd14, 5'd14, 1'b1),     3, "s2.sat0");
    stl(NOF, alu(5'd15, 5'd14, 5'd14, 1'b1),     3, "s2.sat1");
    run(NOF, alu(5'd15, 5'd14, 5'd14, 1'b1), 1'b0, 3, "s2.sat_go");

    // ecall halt: x17 writer ahead, stale x17 while stalled, flush ignored in DRAIN.
    do_reset(FWD, "s3");
    run(FWD, alu(5'd17, 5'd0, 5'd0, 1'b0), 1'b0, 0, "s3.addi17");
    stl(FWD, ecall(1'b0),                        0, "s3.ecall_stall0");
    stl(FWD, ecall(1'b0),                        1, "s3.ecall_stall1");
    run(FWD, ecall(1'b1),                  1'b0, 2, "s3.ecall_go");
    drn(FWD, ecall(1'b1),                  1'b0, 2, "s3.drain0");
    drn(FWD, flushed(ecall(1'b1)),         1'b0, 2, "s3.drain1_flush");
    drn(FWD, ecall(1'b1),                  1'b0, 2, "s3.drain2");
    drn(FWD, ecall(1'b1),                  1'b1, 2, "s3.halted0");
    drn(FWD, bub(),                        1'b1, 2, "s3.halted1");

    // ecall with x17 != 10 passes through; FSM stays in RUN.
    do_reset(FWD, "s4");
    run(FWD, ecall(1'b0),                  1'b0, 0, "s4.ecall_nohalt");
    run(FWD, alu(5'd1, 5'd0, 5'd0, 1'b0),  1'b0, 0, "s4.addi1");
    run(FWD, alu(5'd2, 5'd1, 5'd1, 1'b1),  1'b0, 0, "s4.alu_dep_fwd");
    run(FWD, bub(),                        1'b1, 0, "s4.bubble0");
    run(FWD, bub(),                        1'b1, 0, "s4.bubble1");

    // Flush beats load-use; flushed load must not enter EX.
    do_reset(FWD, "s5");
    run(FWD, ld(5'd5, 5'd1),               1'b0, 0, "s5.lw5");
    run(FWD, flushed(ld(5'd6, 5'd5)),      1'b1, 0, "s5.flush_lu");
    run(FWD, alu(5'd7, 5'd6, 5'd6, 1'b1),  1'b0, 0, "s5.after_flush");
    run(FWD, bub(),                        1'b1, 0, "s5.bubble");

    // Reset pulse in DRAIN: RUN outputs and cleared scoreboard at once.
    do_reset(NOF, "s6");
    run(NOF, alu(5'd9, 5'd0, 5'd0, 1'b0),  1'b0, 0, "s6.addi9");
    run(NOF, ecall(1'b1),                  1'b0, 0, "s6.ecall_halt");
    step(NOF, alu(5'd10, 5'd9, 5'd9, 1'b1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "s6.rst_in_drain");
    run(NOF, bub(),                        1'b1, 0, "s6.bubble");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
